// File: rtl/cgra_arb_pkg.sv
// Shared types and helpers for the CGRA ingress stream arbiter.
// PHIT_SIZE mirrors phit_size from the interface header.
package cgra_arb_pkg;
  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} arb_state_t;

  localparam int DEF_NUM_SRC = 4;
  localparam int PHIT_SIZE   = 32;

  // First set bit at or after ptr, wrapping at n-1; sized for up to 16 sources.
  function automatic logic [3:0] rr_select(input logic [15:0] valid, input logic [3:0] ptr,
                                           input int n);
    logic [3:0] sel;
    logic       found;
    int         j;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < 16; k++) begin
      j = (int'(ptr) + k) % n;
      if (k < n && !found && valid[4'(j)]) begin
        sel   = 4'(j);
        found = 1'b1;
      end
    end
    return sel;
  endfunction
endpackage

// File: rtl/cgra_stream_arb_rr_picker.sv
// Combinational round-robin priority encoder: valid vector + pointer -> index + any.
module rr_picker import cgra_arb_pkg::*; #(
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int IW      = $clog2(DEF_NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] valid,
  input  logic [IW-1:0]      ptr,
  output logic [IW-1:0]      idx,
  output logic               any
);
  assign any = |valid;
  assign idx = IW'(rr_select(16'(valid), 4'(ptr), NUM_SRC));
endmodule

// File: rtl/cgra_stream_arb.sv
// Packet-granular round-robin arbiter onto the single CGRA ingress AXI-Stream.
// Optional per-source packet counters and pkt_count port with CGRA_ARB_STATS_EN.
module cgra_stream_arb import cgra_arb_pkg::*; #(
  parameter int  NUM_SRC = DEF_NUM_SRC,
  parameter int  PHIT_W  = PHIT_SIZE,
  localparam int KW      = PHIT_W / 8,
  localparam int IW      = $clog2(NUM_SRC)
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic [NUM_SRC*PHIT_W-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]    s_axis_tvalid,
  output logic [NUM_SRC-1:0]    s_axis_tready,
  input  logic [NUM_SRC-1:0]    s_axis_tlast,
  input  logic [NUM_SRC*KW-1:0] s_axis_tkeep,
  output logic [PHIT_W-1:0]     m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [KW-1:0]         m_axis_tkeep,
  output logic [IW-1:0]         grant_idx,
  output logic                  busy
`ifdef CGRA_ARB_STATS_EN
  ,
  output logic [NUM_SRC*32-1:0] pkt_count
`endif
);
  arb_state_t    state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic          hs_last;

  rr_picker #(.NUM_SRC(NUM_SRC), .IW(IW)) u_pick (
    .valid (s_axis_tvalid),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Pure combinational steering: no register stage between sources and sink.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tvalid = 1'b0;
    s_axis_tready = '0;
    if (state == XFER) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (IW'(i) == grant_idx) begin
          m_axis_tdata     = s_axis_tdata[i*PHIT_W +: PHIT_W];
          m_axis_tkeep     = s_axis_tkeep[i*KW +: KW];
          m_axis_tlast     = s_axis_tlast[i];
          m_axis_tvalid    = s_axis_tvalid[i];
          s_axis_tready[i] = m_axis_tready;
        end
      end
    end
  end

  assign hs_last = m_axis_tvalid & m_axis_tready & m_axis_tlast;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (pick_any) begin
          grant_idx <= pick_idx;
          state     <= XFER;
          busy      <= 1'b1;
        end
        XFER: if (hs_last) begin
          state  <= IDLE;
          busy   <= 1'b0;
          rr_ptr <= (grant_idx == IW'(NUM_SRC - 1)) ? '0 : grant_idx + IW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CGRA_ARB_STATS_EN
  logic [NUM_SRC-1:0][31:0] cnt;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) cnt <= '0;
    else if (hs_last) begin
      for (int i = 0; i < NUM_SRC; i++)
        if (IW'(i) == grant_idx) cnt[i] <= cnt[i] + 32'd1;
    end
  end

  assign pkt_count = cnt;
`endif
endmodule

// File: doc/cgra_stream_arb.md
# cgra_stream_arb

Packet-granular round-robin arbiter that shares the single CGRA ingress AXI-Stream (phit-wide) among `NUM_SRC` upstream stream sources. Sits between the stream emulators or network ports and the CGRA input. A grant is held from the first beat of a packet through its `tlast` beat, so packets are never interleaved.

## Interface
Parameters:
- `NUM_SRC`, 4, number of requesting streams (2..16).
- `PHIT_W`, `phit_size`, data width in bits; must be a multiple of 8.

Ports (clock and reset first):
- `ap_clk`  in  1  single clock; all logic is on its rising edge.
- `ap_rst`  in  1  synchronous, active-high reset.
- `s_axis_tdata`  in  NUM_SRC*PHIT_W  source data; slice i is source i.
- `s_axis_tvalid`  in  NUM_SRC  per-source valid.
- `s_axis_tready`  out  NUM_SRC  per-source ready.
- `s_axis_tlast`  in  NUM_SRC  per-source end of packet.
- `s_axis_tkeep`  in  NUM_SRC*PHIT_W/8  per-source byte keep.
- `m_axis_tdata`  out  PHIT_W  arbitrated data.
- `m_axis_tvalid`  out  1  arbitrated valid.
- `m_axis_tready`  in  1  downstream ready.
- `m_axis_tlast`  out  1  arbitrated end of packet.
- `m_axis_tkeep`  out  PHIT_W/8  arbitrated keep.
- `grant_idx`  out  $clog2(NUM_SRC)  currently or most recently granted source.
- `busy`  out  1  high while a grant is held (state XFER).
- `pkt_count`  out  NUM_SRC*32  completed-packet count per source. Present only with `CGRA_ARB_STATS_EN`.

## Operation
States:
- **IDLE**
  - All `s_axis_tready` are 0 and `m_axis_tvalid` is 0.
  - If any `s_axis_tvalid` is high, select the first set index at or after `rr_ptr`, searching upward with wrap at `NUM_SRC-1` to 0.
  - Register the selection into `grant_idx` and go to XFER.
- **XFER**
  - `m_axis_*` come combinationally from slice `grant_idx`.
  - `s_axis_tready[grant_idx]` = `m_axis_tready`; every other `s_axis_tready` is 0.
  - On a handshake (valid & ready) with `tlast`: go to IDLE and set `rr_ptr` = `grant_idx`+1, wrapping to 0 at `NUM_SRC`.
  - If the granted source drops `tvalid` mid-packet, the grant is held and `m_axis_tvalid` follows it; there is no timeout.

Rules:
- AXIS rules are preserved end to end. The block never changes data, keep or last, and never drops or duplicates a beat.
- Requests that arrive during XFER wait. They are evaluated at the next IDLE cycle.
- A single-beat packet (`tlast` on the first beat) is legal: one XFER cycle, then IDLE.
- Resets:
  - State is IDLE, `rr_ptr` 0, `grant_idx` 0, `busy` 0.
  - All `s_axis_tready` are 0, `m_axis_tvalid` is 0.
  - `m_axis_tdata`, `m_axis_tkeep` and `m_axis_tlast` drive 0 in IDLE.
  - Counters are 0.
- Reset asserted mid-packet abandons the packet. Outputs reach their reset values on the next edge, and the downstream sees a truncated packet without `tlast`; upstream reset must be coordinated.

## Timing
- Arbitration latency: 1 cycle. Source valid in IDLE at cycle N gives `m_axis_tvalid` at cycle N+1.
- Throughput: one beat per cycle inside a packet.
- There is exactly one dead cycle (IDLE) between consecutive packets, including back-to-back packets from the same source.
- Combinational paths:
  - `m_axis_tready` to `s_axis_tready`.
  - Source data/valid/last/keep to `m_axis_*`.
  - There is no registered stage. Place the block before a register slice if timing requires it.
- Fairness: with all sources requesting continuously, each source receives one packet per `NUM_SRC` grants.

## Configuration
- `CGRA_ARB_STATS_EN` defined:
  - Adds a 32-bit counter per source and the `pkt_count` port.
  - A counter increments on each `tlast` handshake of its source and wraps modulo 2^32.
  - Counters clear only on `ap_rst`.
- `CGRA_ARB_STATS_EN` undefined:
  - No counters and no `pkt_count` port.
  - All other behaviour is identical.

## Structure
- Shared package `cgra_arb_pkg`:
  - State enum `arb_state_t` {IDLE, XFER}.
  - Default `NUM_SRC`.
  - Function `rr_select(valid, ptr)` that returns the next index.
- `phit_size` continues to come from `my_interface.vh`.
- One sub-module is natural: `rr_picker`, the combinational round-robin priority encoder (valid vector + pointer gives index + any). The top keeps the FSM, mux and counters.

## Test plan
- **Reset values:** hold `ap_rst` 3 cycles with all sources valid. Required: `m_axis_tvalid`=0, all `s_axis_tready`=0, `grant_idx`=0, `busy`=0; first grant to source 0 one cycle after release.
- **Round-robin:** all four sources each send 3-beat packets continuously with `m_axis_tready`=1. Required: grant order 0,1,2,3,0; each packet takes 3 cycles plus 1 idle; no interleaving.
- **Backpressure:** source 2 sends an 8-beat packet while `m_axis_tready` toggles 1,0,1,0. Required: exactly 8 beats out in order with `tlast` only on beat 8; `s_axis_tready[2]` mirrors `m_axis_tready`; others stay 0.
- **Pointer wrap and single-beat packets:** grant source 3, then only source 1 requests with a 1-beat packet. Required: `rr_ptr` wraps to 0, source 1 is granted, and XFER lasts 1 cycle.
- **Reset mid-packet:** assert `ap_rst` at beat 2 of a 5-beat packet. Required: next cycle `m_axis_tvalid`=0, state IDLE, `rr_ptr`=0.
- **Stats (with `CGRA_ARB_STATS_EN`):** send 5 packets from source 1 and 2 from source 0. Required: `pkt_count` slice 1 = 5, slice 0 = 2, others 0.
